level_column_feeder: RTL and testbench

Producer end of the block-column shift interface. It fetches 30-bit block-ID columns (10 rows x 3-bit ID; row r sits in bits 3r+2:3r) from level memory over a req/ack read port. It then presents each column on new_block_id with a one-cycle Shift pulse to the on-screen block array. After reset it fills the visible window, then supplies one column per scroll request from the scroll/camera logic.

---
 rtl/level_pkg.sv | 31 +++
 rtl/level_column_feeder_if.sv | 32 +++
 rtl/scroll_pend_counter.sv | 37 +++
 rtl/level_column_feeder.sv | 131 +++++++++++++
 tb/tb_level_column_feeder.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/level_pkg.sv
// Shared types and constants for the level column feeder.
package level_pkg;

    localparam int unsigned BLOCK_ID_W = 3;
    localparam int unsigned ROWS       = 10;
    localparam int unsigned COL_BITS   = BLOCK_ID_W * ROWS;
    localparam int unsigned BLOCK_PX   = 40;
    localparam int unsigned MEM_DW     = 16;
    localparam int unsigned HI_BITS    = COL_BITS - MEM_DW;

    typedef enum logic [BLOCK_ID_W-1:0] {
        AIR      = 3'd0,
        BRICK    = 3'd1,
        QUESTION = 3'd3
    } block_id_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH_LO = 2'd1,
        FETCH_HI = 2'd2,
        EMIT     = 2'd3
    } feed_state_e;

    typedef logic [COL_BITS-1:0] column_t;

    // Column emitted once the level memory has run out.
    function automatic column_t air_column();
        return {ROWS{AIR}};
    endfunction

endpackage

// File: rtl/level_column_feeder_if.sv
// Column-feed bundle: scroll input, level-memory read port and block-array shift output.
interface level_column_feeder_if
    import level_pkg::*;
#(
    parameter int unsigned COL_W = 8
) ();

    logic                scroll_req;
    logic                mem_rd_req;
    logic [COL_W:0]      mem_addr;
    logic                mem_rd_ack;
    logic [MEM_DW-1:0]   mem_rdata;
    column_t             new_block_id;
    logic                Shift;
    logic [COL_W-1:0]    col_index;
    logic                level_end;
    logic                init_done;
    logic                pend_ovf;

    modport master (
        input  scroll_req, mem_rd_ack, mem_rdata,
        output mem_rd_req, mem_addr, new_block_id, Shift,
               col_index, level_end, init_done, pend_ovf
    );

    modport slave (
        output scroll_req, mem_rd_ack, mem_rdata,
        input  mem_rd_req, mem_addr, new_block_id, Shift,
               col_index, level_end, init_done, pend_ovf
    );

endinterface

// File: rtl/scroll_pend_counter.sv
// Saturating up/down counter of outstanding scroll requests with sticky overflow.
module scroll_pend_counter #(
    parameter int unsigned PEND_W = 3
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              i_inc,
    input  logic              i_dec,
    output logic [PEND_W-1:0] o_count,
    output logic              o_ovf
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    logic [PEND_W-1:0] r_count;
    logic              r_ovf;

    // Simultaneous inc and dec cancel; a request lost at saturation is flagged.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (i_inc && !i_dec) begin
            if (r_count == PEND_MAX) begin
                r_ovf <= 1'b1;
            end else begin
                r_count <= r_count + PEND_W'(1);
            end
        end else if (i_dec && !i_inc && (r_count != '0)) begin
            r_count <= r_count - PEND_W'(1);
        end
    end

    assign o_count = r_count;
    assign o_ovf   = r_ovf;

endmodule

// File: rtl/level_column_feeder.sv
// Fetches 30-bit block-ID columns from level memory and shifts them into the block array.
// Define LEVEL_LOOP_EN to wrap the level back to column 0 instead of emitting air at the end.
module level_column_feeder
    import level_pkg::*;
#(
    parameter int unsigned LEVEL_COLS = 212,
    parameter int unsigned VIEW_COLS  = 10,
    parameter int unsigned COL_W      = 8,
    parameter int unsigned PEND_W     = 3
) (
    input  logic                   Clk,
    input  logic                   Reset,
    level_column_feeder_if.master  bus
);

    localparam int unsigned FILL_W = $clog2(VIEW_COLS + 1);

    feed_state_e         r_state;
    logic [FILL_W-1:0]   r_fill_cnt;
    logic [COL_W-1:0]    r_col_index;
    logic [MEM_DW-1:0]   r_lo;
    logic                r_mem_rd_req;
    logic [COL_W:0]      r_mem_addr;
    column_t             r_new_block_id;
    logic                r_shift;
    logic                r_level_end;
    logic                r_init_done;

    logic [PEND_W-1:0]   w_pend;
    logic                w_pend_ovf;
    logic                w_pend_dec;
    logic                w_work;
    logic                w_exhausted;
    logic [COL_W-1:0]    w_col_next;
    logic                w_unused_rdata;

    assign w_work         = (r_fill_cnt != '0) || (w_pend != '0);
    assign w_pend_dec     = (r_state == EMIT) && (r_fill_cnt == '0);
    assign w_unused_rdata = ^bus.mem_rdata[MEM_DW-1:HI_BITS];

`ifdef LEVEL_LOOP_EN
    assign w_exhausted = 1'b0;
    assign w_col_next  = (r_col_index == COL_W'(LEVEL_COLS - 1)) ? '0
                                                                  : r_col_index + COL_W'(1);
`else
    assign w_exhausted = (r_col_index >= COL_W'(LEVEL_COLS));
    assign w_col_next  = w_exhausted ? r_col_index : r_col_index + COL_W'(1);
`endif

    scroll_pend_counter #(
        .PEND_W (PEND_W)
    ) u_pend (
        .Clk     (Clk),
        .Reset   (Reset),
        .i_inc   (bus.scroll_req),
        .i_dec   (w_pend_dec),
        .o_count (w_pend),
        .o_ovf   (w_pend_ovf)
    );

    // Column index advances on entry to EMIT so level_end can register it one cycle later.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state        <= IDLE;
            r_fill_cnt     <= FILL_W'(VIEW_COLS);
            r_col_index    <= '0;
            r_lo           <= '0;
            r_mem_rd_req   <= 1'b0;
            r_mem_addr     <= '0;
            r_new_block_id <= '0;
            r_shift        <= 1'b0;
            r_level_end    <= 1'b0;
            r_init_done    <= 1'b0;
        end else begin
            r_shift <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_work) begin
                        if (w_exhausted) begin
                            r_new_block_id <= air_column();
                            r_shift        <= 1'b1;
                            r_col_index    <= w_col_next;
                            r_state        <= EMIT;
                        end else begin
                            r_mem_rd_req <= 1'b1;
                            r_mem_addr   <= {r_col_index, 1'b0};
                            r_state      <= FETCH_LO;
                        end
                    end
                end
                FETCH_LO: begin
                    if (bus.mem_rd_ack) begin
                        r_lo       <= bus.mem_rdata;
                        r_mem_addr <= {r_col_index, 1'b1};
                        r_state    <= FETCH_HI;
                    end
                end
                FETCH_HI: begin
                    if (bus.mem_rd_ack) begin
                        r_mem_rd_req   <= 1'b0;
                        r_new_block_id <= {bus.mem_rdata[HI_BITS-1:0], r_lo};
                        r_shift        <= 1'b1;
                        r_col_index    <= w_col_next;
                        r_state        <= EMIT;
                    end
                end
                EMIT: begin
                    r_state     <= IDLE;
                    r_level_end <= (r_col_index == COL_W'(LEVEL_COLS));
                    if (r_fill_cnt != '0) begin
                        r_fill_cnt <= r_fill_cnt - FILL_W'(1);
                        if (r_fill_cnt == FILL_W'(1)) begin
                            r_init_done <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.mem_rd_req   = r_mem_rd_req;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.new_block_id = r_new_block_id;
    assign bus.Shift        = r_shift;
    assign bus.col_index    = r_col_index;
    assign bus.level_end    = r_level_end;
    assign bus.init_done    = r_init_done;
    assign bus.pend_ovf     = w_pend_ovf;

endmodule

// File: tb/tb_level_column_feeder.sv
// Bench for level_column_feeder with a 12-column level and a variable-latency memory model.
module tb_level_column_feeder;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    level_column_feeder_if #(.COL_W(8)) ifc ();

    level_column_feeder #(
        .LEVEL_COLS (12),
        .VIEW_COLS  (10),
        .COL_W      (8),
        .PEND_W     (3)
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (ifc)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [29:0] shift_q[$];
    logic [8:0]  addr_log[$];
    int   stab_err  = 0;
    int   pulse_err = 0;
    int   max_dly   = 0;
    int   m_wait    = 0;
    logic hold_en   = 1'b0;
    logic [8:0] hold_addr = 9'd0;
    logic m_req_prev = 1'b0;
    logic m_ack_prev = 1'b0;
    logic [8:0] m_addr_prev = 9'd0;
    logic shift_prev = 1'b0;
    logic arm = 1'b0;
    logic init_at10 = 1'b1;
    logic init_after = 1'b0;

    function automatic logic [15:0] mem_word(input logic [8:0] a);
        logic [7:0] c;
        c = a[8:1];
        if (!a[0]) return (c == 8'd10) ? 16'h0049 : 16'(c);
        if (c == 8'd11) return 16'hC005;
        if (c == 8'd3)  return 16'h3FFF;
        return 16'h0000;
    endfunction

    function automatic logic [29:0] exp_id(input int k);
        int c;
`ifdef LEVEL_LOOP_EN
        c = k % 12;
`else
        if (k >= 12) return 30'h0;
        c = k;
`endif
        case (c)
            3:       return 30'h3FFF_0003;
            10:      return 30'h0000_0049;
            11:      return 30'h0005_000B;
            default: return 30'(c);
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Memory model: drives ack/data at the falling edge, checks req/addr hold while waiting.
    always @(negedge clk) begin
        if (ifc.mem_rd_req) begin
            if (m_req_prev && !m_ack_prev && (ifc.mem_addr != m_addr_prev)) stab_err++;
            if (m_wait == 0 && !(hold_en && ifc.mem_addr == hold_addr)) begin
                ifc.mem_rd_ack = 1'b1;
                ifc.mem_rdata  = mem_word(ifc.mem_addr);
                addr_log.push_back(ifc.mem_addr);
                m_wait = (max_dly == 0) ? 0 : int'($urandom_range(max_dly, 0));
            end else begin
                ifc.mem_rd_ack = 1'b0;
                ifc.mem_rdata  = 16'($urandom);
                if (m_wait > 0) m_wait--;
            end
        end else begin
            if (m_req_prev && !m_ack_prev && !rst) stab_err++;
            ifc.mem_rd_ack = 1'b0;
        end
        m_req_prev  = ifc.mem_rd_req;
        m_addr_prev = ifc.mem_addr;
        m_ack_prev  = ifc.mem_rd_ack;
    end

    // Shift monitor: collects columns, checks single-cycle strobes and init_done timing.
    always @(negedge clk) begin
        if (arm) begin
            init_after = ifc.init_done;
            arm = 1'b0;
        end
        if (ifc.Shift) begin
            if (shift_prev) pulse_err++;
            if (shift_q.size() == 9) init_at10 = ifc.init_done;
            shift_q.push_back(ifc.new_block_id);
            if (shift_q.size() == 10) arm = 1'b1;
        end
        shift_prev = ifc.Shift;
    end

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        shift_q.delete();
        addr_log.delete();
        stab_err = 0; pulse_err = 0; m_wait = 0;
        init_at10 = 1'b1; init_after = 1'b0;
        check({tag, "_reset_outputs"},
              64'({ifc.Shift, ifc.mem_rd_req, ifc.mem_addr, ifc.new_block_id,
                   ifc.col_index, ifc.level_end, ifc.init_done, ifc.pend_ovf}), 64'h0);
        rst = 1'b0;
    endtask

    task automatic settle(input int n);
        for (int c = 0; c < 3000 && shift_q.size() < n; c++) @(negedge clk);
        repeat (40) @(negedge clk);
    endtask

    typedef struct {
        int         n_scroll;
        int         dly;
        int         exp_shifts;
        logic       exp_ovf;
        logic [7:0] exp_col;
        logic       exp_end;
        int         exp_acks;
    } row_t;

    initial begin
        row_t rows[4];
        string t;
        rows[0] = '{0, 0, 10, 1'b0, 8'd10, 1'b0, 20};
`ifdef LEVEL_LOOP_EN
        rows[1] = '{9, 7, 17, 1'b1, 8'd5,  1'b0, 34};
        rows[2] = '{2, 3, 12, 1'b0, 8'd0,  1'b0, 24};
        rows[3] = '{7, 1, 17, 1'b0, 8'd5,  1'b0, 34};
`else
        rows[1] = '{9, 7, 17, 1'b1, 8'd12, 1'b1, 24};
        rows[2] = '{2, 3, 12, 1'b0, 8'd12, 1'b1, 24};
        rows[3] = '{7, 1, 17, 1'b0, 8'd12, 1'b1, 24};
`endif
        ifc.scroll_req = 1'b0;
        ifc.mem_rd_ack = 1'b0;
        ifc.mem_rdata  = 16'h0;

        for (int r = 0; r < 4; r++) begin
            t = $sformatf("row%0d", r);
            max_dly = rows[r].dly;
            do_reset(t);
            for (int i = 0; i < rows[r].n_scroll; i++) begin
                ifc.scroll_req = 1'b1;
                @(negedge clk);
            end
            ifc.scroll_req = 1'b0;
            settle(rows[r].exp_shifts);
            check({t, "_shift_count"}, 64'(shift_q.size()), 64'(rows[r].exp_shifts));
            for (int k = 0; k < rows[r].exp_shifts && k < shift_q.size(); k++)
                check($sformatf("%s_col%0d", t, k), 64'(shift_q[k]), 64'(exp_id(k)));
            check({t, "_pend_ovf"},   64'(ifc.pend_ovf),  64'(rows[r].exp_ovf));
            check({t, "_col_index"},  64'(ifc.col_index), 64'(rows[r].exp_col));
            check({t, "_level_end"},  64'(ifc.level_end), 64'(rows[r].exp_end));
            check({t, "_mem_acks"},   64'(addr_log.size()), 64'(rows[r].exp_acks));
            check({t, "_init_at10"},  64'(init_at10),  64'h0);
            check({t, "_init_after"}, 64'(init_after), 64'h1);
            check({t, "_req_stable"}, 64'(stab_err),   64'h0);
            check({t, "_shift_pulse"}, 64'(pulse_err), 64'h0);
        end

        // Single scroll after the fill, then two more reaching the end of the level.
        max_dly = 0;
        do_reset("scroll");
        settle(10);
        shift_q.delete();
        addr_log.delete();
        ifc.scroll_req = 1'b1;
        @(negedge clk);
        ifc.scroll_req = 1'b0;
        settle(1);
        check("scroll1_count", 64'(shift_q.size()), 64'd1);
        check("scroll1_data",  64'(shift_q[0]), 64'h49);
        check("scroll1_naddr", 64'(addr_log.size()), 64'd2);
        check("scroll1_addr0", 64'(addr_log[0]), 64'd20);
        check("scroll1_addr1", 64'(addr_log[1]), 64'd21);
        ifc.scroll_req = 1'b1;
        repeat (2) @(negedge clk);
        ifc.scroll_req = 1'b0;
        settle(3);
        check("scroll3_count", 64'(shift_q.size()), 64'd3);
        check("scroll3_col11", 64'(shift_q[1]), 64'h0005_000B);
        check("scroll3_last",  64'(shift_q[2]), 64'h0);
`ifdef LEVEL_LOOP_EN
        check("scroll3_naddr", 64'(addr_log.size()), 64'd6);
        check("scroll3_wrap0", 64'(addr_log[4]), 64'd0);
        check("scroll3_wrap1", 64'(addr_log[5]), 64'd1);
        check("scroll3_lend",  64'(ifc.level_end), 64'h0);
`else
        check("scroll3_naddr", 64'(addr_log.size()), 64'd4);
        check("scroll3_addr3", 64'(addr_log[3]), 64'd23);
        check("scroll3_lend",  64'(ifc.level_end), 64'h1);
`endif

        // Reset while column 2 is waiting for its upper half.
        hold_addr = 9'd5;
        hold_en   = 1'b1;
        do_reset("midfetch");
        for (int c = 0; c < 500 && !(ifc.mem_rd_req && ifc.mem_addr == 9'd5); c++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("midfetch_waiting", 64'({ifc.mem_rd_req, ifc.mem_addr}), 64'({1'b1, 9'd5}));
        check("midfetch_col_before", 64'(ifc.col_index), 64'd2);
        rst = 1'b1;
        @(negedge clk);
        check("midfetch_req_drop", 64'(ifc.mem_rd_req), 64'h0);
        check("midfetch_shift",    64'(ifc.Shift),      64'h0);
        check("midfetch_col",      64'(ifc.col_index),  64'h0);
        hold_en = 1'b0;
        do_reset("refill");
        settle(10);
        check("refill_count",  64'(shift_q.size()), 64'd10);
        check("refill_addr0",  64'(addr_log[0]), 64'd0);
        check("refill_first",  64'(shift_q[0]), 64'h0);
        check("refill_col3",   64'(shift_q[3]), 64'h3FFF_0003);
        check("refill_col9",   64'(shift_q[9]), 64'h9);
        check("refill_index",  64'(ifc.col_index), 64'd10);
        check("refill_init",   64'(ifc.init_done), 64'h1);
        check("refill_stable", 64'(stab_err), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
